// File: rtl/imem_pkg.sv
// Shared sizing defaults and word/address types for the instruction memory.
package imem_pkg;

    localparam int IMEM_DATA_W = 32;
    localparam int IMEM_ADDR_W = 5;
    localparam int IMEM_DEPTH  = 2 ** IMEM_ADDR_W;

    typedef logic [IMEM_DATA_W-1:0] word_t;
    typedef logic [IMEM_ADDR_W-1:0] addr_t;

endpackage

// File: rtl/imem_array.sv
// Flip-flop word array with asynchronous whole-array clear and per-word write decode.
module imem_array
    import imem_pkg::*;
#(
    parameter int DATA_W = IMEM_DATA_W,
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DEPTH  = IMEM_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr,
    input  logic [ADDR_W-1:0]            addr,
    input  logic [DATA_W-1:0]            wdata,
    output logic [DEPTH-1:0][DATA_W-1:0] words
);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            logic              hit;
            logic [DATA_W-1:0] word_d;
            logic [DATA_W-1:0] word_q;

            always_comb begin
                hit    = wr && (addr == ADDR_W'(gi));
                word_d = word_q;
                if (hit) begin
                    word_d = wdata;
                end
            end

            // Registers rather than block RAM: the whole array must clear asynchronously.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    word_q <= '0;
                end else begin
                    word_q <= word_d;
                end
            end

            assign words[gi] = word_q;
        end
    endgenerate

endmodule

// File: rtl/imemory.sv
// 32x32 instruction/data memory: synchronous write, combinational read gated by rd.
module imemory
    import imem_pkg::*;
#(
    parameter int DATA_W = IMEM_DATA_W,
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DEPTH  = IMEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd,
    input  logic              wr,
    output logic [DATA_W-1:0] rdata
);

    logic [DEPTH-1:0][DATA_W-1:0] words;

    imem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (wr),
        .addr  (addr),
        .wdata (wdata),
        .words (words)
    );

    // Read sees the array directly, so a write shows up right after its edge.
    always_comb begin
        rdata = '0;
        if (rd) begin
            rdata = words[addr];
        end
    end

endmodule

// File: tb/tb_imemory.sv
// Self-checking bench for imemory: vector table plus hand sequences, scoreboard queue of expected rdata.
module tb_imemory;

    logic        clk;
    logic        rst_n;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        rd;
    logic        wr;
    logic [31:0] rdata;

    int n_vec  = 0;
    int n_miss = 0;
    logic [31:0] expect_q[$];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;   // rdata expected before this vector's clock edge
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs[NVEC];

    imemory dut (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (addr),
        .wdata (wdata),
        .rd    (rd),
        .wr    (wr),
        .rdata (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, rdata=%08h required finish", rdata);
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input logic [31:0] e);
        expect_q.push_back(e);
    endtask

    task automatic chk(input string name);
        logic [31:0] e;
        n_vec++;
        if (expect_q.size() == 0) begin
            n_miss++;
            $display("FAIL %s: scoreboard empty, got %08h", name, rdata);
        end else begin
            e = expect_q.pop_front();
            if (rdata !== e) begin
                n_miss++;
                $display("FAIL %s: rdata=%08h expected %08h", name, rdata, e);
            end else begin
                $display("ok   %s: addr=%0d rd=%0b wr=%0b rst_n=%0b rdata=%08h",
                         name, addr, rd, wr, rst_n, rdata);
            end
        end
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 5'd0,  32'hBFC00000, 32'h00000000};
        vecs[1]  = '{1'b1, 1'b0, 5'd0,  32'h00000000, 32'hBFC00000};
        vecs[2]  = '{1'b1, 1'b1, 5'd0,  32'hBFE80000, 32'hBFC00000};
        vecs[3]  = '{1'b1, 1'b0, 5'd0,  32'h00000000, 32'hBFE80000};
        vecs[4]  = '{1'b0, 1'b1, 5'd0,  32'hBFC00000, 32'h00000000};
        vecs[5]  = '{1'b0, 1'b0, 5'd0,  32'h00000000, 32'h00000000};
        vecs[6]  = '{1'b1, 1'b0, 5'd0,  32'h00000000, 32'hBFC00000};
        vecs[7]  = '{1'b0, 1'b0, 5'd0,  32'h00000000, 32'h00000000};
        vecs[8]  = '{1'b0, 1'b1, 5'd0,  32'h11111111, 32'h00000000};
        vecs[9]  = '{1'b1, 1'b1, 5'd31, 32'hFFFFFFFF, 32'h00000000};
        vecs[10] = '{1'b1, 1'b0, 5'd0,  32'h00000000, 32'h11111111};
        vecs[11] = '{1'b1, 1'b0, 5'd31, 32'h00000000, 32'hFFFFFFFF};
        vecs[12] = '{1'b1, 1'b0, 5'd1,  32'h00000000, 32'h00000000};
        vecs[13] = '{1'b1, 1'b1, 5'd5,  32'hAAAA5555, 32'h00000000};
        vecs[14] = '{1'b1, 1'b0, 5'd5,  32'h00000000, 32'hAAAA5555};
        vecs[15] = '{1'b1, 1'b1, 5'd5,  32'h12345678, 32'hAAAA5555};
        vecs[16] = '{1'b1, 1'b0, 5'd5,  32'h00000000, 32'h12345678};
        vecs[17] = '{1'b1, 1'b1, 5'd7,  32'hDEADBEEF, 32'h00000000};
        vecs[18] = '{1'b1, 1'b0, 5'd7,  32'h00000000, 32'hDEADBEEF};

        // Reset, then read address 0 and 31 while still in reset
        rst_n = 1'b0; rd = 1'b1; wr = 1'b0; addr = 5'd0; wdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        push_exp(32'h0); #1 chk("reset_addr0");
        addr = 5'd31;
        push_exp(32'h0); #1 chk("reset_addr31");
        @(negedge clk);
        rst_n = 1'b1;

        // Table: check before each edge, the following vector observes the edge's effect
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            rd = vecs[i].rd; wr = vecs[i].wr; addr = vecs[i].addr; wdata = vecs[i].wdata;
            push_exp(vecs[i].exp);
            #1 chk($sformatf("vec%0d", i));
        end

        // Read gating without any clock edge; addr 0 holds 0x11111111
        @(negedge clk);
        wr = 1'b0; addr = 5'd0; rd = 1'b1;
        push_exp(32'h11111111); #1 chk("gate_rd1");
        rd = 1'b0;
        push_exp(32'h00000000); #1 chk("gate_rd0");
        rd = 1'b1;
        push_exp(32'h11111111); #1 chk("gate_rd1_again");

        // Reset mid-operation: asynchronous clear, write during reset discarded
        addr = 5'd5;
        push_exp(32'h12345678); #1 chk("pre_reset_addr5");
        rst_n = 1'b0;
        push_exp(32'h00000000); #1 chk("async_clear_addr5");
        wr = 1'b1; wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        push_exp(32'h00000000); chk("write_during_reset");
        @(negedge clk);
        wr = 1'b0; rst_n = 1'b1;
        for (int a = 0; a < 32; a++) begin
            addr = 5'(a);
            push_exp(32'h00000000);
            #1 chk($sformatf("post_reset_addr%0d", a));
        end

        // First edge after release accepts a write
        @(negedge clk);
        addr = 5'd3; wdata = 32'h0BADF00D; wr = 1'b1; rd = 1'b1;
        push_exp(32'h00000000); #1 chk("first_write_before");
        @(negedge clk);
        wr = 1'b0;
        push_exp(32'h0BADF00D); #1 chk("first_write_after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
